// File: rtl/gf_matvec_seq.sv
// Sequential GF(2^W) matrix-vector multiplier: one result row per clock,
// with a writable N x N coefficient matrix that reloads its default on reset.
//
// state | meaning
// IDLE  | waiting for a vector; coefficient writes accepted here only
// BUSY  | computing row row_q of z = M (x) y, one row per cycle
// DONE  | result held on out_data until the consumer takes it
module gf_matvec_seq #(
  parameter int            N    = 4,
  parameter int            W    = 8,
  parameter logic [W-1:0]  POLY = 8'h69
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N*W-1:0]                in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N*W-1:0]                out_data,
  input  logic                          coef_we,
  input  logic [$clog2(N*N)-1:0]        coef_addr,
  input  logic [W-1:0]                  coef_data,
  output logic                          coef_err
);

  localparam int AW = $clog2(N*N);
  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [RW-1:0]    row_q;
  logic             out_valid_q;
  logic             coef_err_q;
  logic [N*W-1:0]   y_q;
  logic [N*W-1:0]   out_data_q;
  logic [N*W-1:0]   out_data_d;
  logic [W-1:0]     row_z;
  logic [W-1:0]     mat_q [N*N];
  logic             coef_wr_ok;

  // Shift-and-add multiply; x^W overflow folded back in via POLY.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p;
    logic [W-1:0] aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < W; k++) begin
      if (b[k]) p = p ^ aa;
      aa = aa[W-1] ? ((aa << 1) ^ POLY) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] mds_entry(input int idx);
    logic [7:0] v;
    case (idx)
      0, 7, 10, 13:          v = 8'h01;
      2, 3, 4, 9, 15:        v = 8'h5B;
      default:               v = 8'hEF;
    endcase
    return v;
  endfunction

  function automatic logic [W-1:0] reset_entry(input int idx);
    if (N == 4 && W == 8) return W'(mds_entry(idx));
    return (idx / N == idx % N) ? W'(1) : '0;
  endfunction

  assign coef_wr_ok = coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < (AW+1)'(N*N));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N*N; k++) mat_q[k] <= reset_entry(k);
    end else if (coef_wr_ok) begin
      mat_q[coef_addr] <= coef_data;
    end
  end

  always_comb begin
    row_z = '0;
    for (int j = 0; j < N; j++)
      row_z = row_z ^ gf_mul(mat_q[AW'(int'(row_q) * N + j)], y_q[W*j +: W]);
  end

  // Only the current row changes; rows not yet reached keep the previous result.
  always_comb begin
    out_data_d = out_data_q;
    out_data_d[W*int'(row_q) +: W] = row_z;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_err_q  <= 1'b0;
      y_q         <= '0;
    end else begin
      coef_err_q <= coef_we && !coef_wr_ok;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            y_q     <= in_data;
            row_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          out_data_q <= out_data_d;
          if (row_q == RW'(N-1)) begin
            row_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              y_q     <= in_data;
              row_q   <= '0;
              state_q <= BUSY;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_gf_matvec_seq.sv
// Directed bench for gf_matvec_seq: default Twofish MDS instance plus an
// N=2, W=4 identity-matrix instance.
module tb_gf_matvec_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, coef_we, coef_err;
  logic [31:0] in_data, out_data;
  logic [3:0]  coef_addr;
  logic [7:0]  coef_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_coef_we, b_coef_err;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_coef_addr;
  logic [3:0]  b_coef_data;

  int n_checks = 0;
  int n_errors = 0;

  gf_matvec_seq dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err)
  );

  gf_matvec_seq #(.N(2), .W(4), .POLY(4'h3)) dut_b (
    .clk(clk), .reset(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data), .coef_err(b_coef_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [31:0] vec);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = vec;
    check("in_ready_idle", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_vec(input string tag, input logic [31:0] vec, input logic [31:0] exp);
    accept(vec);
    wait_done(tag, 4);
    check(tag, out_data, exp);
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         lat;

    rst_n = 1'b0;
    in_valid = 0; in_data = '0; out_ready = 0; coef_we = 0; coef_addr = '0; coef_data = '0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_coef_we = 0; b_coef_addr = '0; b_coef_data = '0;
    #23;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_coef_err", {31'b0, coef_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec("vec_e0", 32'h00000001, 32'hEFEF5B01);
    run_vec("vec_e1", 32'h00000100, 32'h015BEFEF);
    run_vec("vec_x2", 32'h00000002, 32'hB7B7B602);
    run_vec("vec_all1", 32'h01010101, 32'h5A5A5AEE);

    // Stall in DONE, then a handoff accept on the releasing edge.
    accept(32'h00000001);
    wait_done("stall", 4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_data", out_data, 32'hEFEF5B01);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h00000100; out_ready = 1'b1;
    #1 check("handoff_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b0;
    check("handoff_valid_low", {31'b0, out_valid}, 32'd0);
    wait_done("handoff", 4);
    check("handoff_data", out_data, 32'h015BEFEF);
    drain("handoff");

    // Coefficient write while BUSY is rejected.
    accept(32'h00000001);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'h02;
    @(posedge clk);
    #1 coef_we = 1'b0;
    check("busy_wr_err", {31'b0, coef_err}, 32'd1);
    @(posedge clk);
    #1 check("busy_wr_err_pulse", {31'b0, coef_err}, 32'd0);
    wait_done("busy_wr", 2);
    check("busy_wr_data", out_data, 32'hEFEF5B01);
    drain("busy_wr");

    // Coefficient write in IDLE takes effect.
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'h02;
    @(posedge clk);
    #1 coef_we = 1'b0;
    check("idle_wr_err", {31'b0, coef_err}, 32'd0);
    run_vec("idle_wr", 32'h00000001, 32'hEFEF5B02);

    // Reset at BUSY row 2; rows 0..1 already rewritten, rows 2..3 still old.
    accept(32'h00000002);
    @(posedge clk);
    @(posedge clk);
    #1 check("partial_rows", out_data, 32'hEFEFB604);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_data", out_data, 32'h0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("post_rst", 32'h00000001, 32'hEFEF5B01);

    // Small instance with identity matrix.
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom_range(0, 255));
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_data  = v;
      @(posedge clk);
      #1 b_in_valid = 1'b0;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk);
        #1;
        if (b_out_valid) begin
          lat = k;
          break;
        end
      end
      check("ident_latency", lat, 32'd2);
      check("ident_data", {24'b0, b_out_data}, {24'b0, v});
      @(negedge clk);
      b_out_ready = 1'b1;
      @(posedge clk);
      #1 b_out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
